// File: rtl/dmem_bus_if_pkg.sv
// Shared types and constants for the data-memory bus interface:
// FSM state encoding, bus SIZE codes, RV32I load/store funct3 values,
// the well-known MMIO addresses, and small lane/alignment helpers.
package dmem_bus_if_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'hFF00_0000;

    // funct3[1:0] selects the access width; the unused encoding 11 falls back to word.
    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Store data is placed in the low lanes with the unused upper bits cleared.
    function automatic logic [31:0] store_lane(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {24'h0, wdata[7:0]};
            SZ_HALF: return {16'h0, wdata[15:0]};
            default: return wdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return (addr_lo != 2'b00);
            SZ_HALF: return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-result extension: picks the loaded byte/half/word out of the raw
// bus data and sign- or zero-extends it according to the load funct3.
module dmem_load_ext
    import dmem_bus_if_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Width and signedness both come straight from funct3.
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'h0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface between the MEM stage and an asynchronous
// handshake bus (MREQ/WRITE/SIZE/DAD out, ACKD_n in, DDT bidirectional).
// A request is latched in the accept cycle, held on the bus until ACKD_n
// falls, and completed with a one-cycle rsp_valid pulse.
//
// Build option: DMEM_BUS_IF_MISALIGN_TRAP_EN -- when defined, misaligned
// word/half accesses never reach the bus and complete with misalign=1.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus quiet; accept a request unless rsp_valid is high
// BUSY  | MREQ high, address/control/store data held until ACKD_n=0
module dmem_bus_if
    import dmem_bus_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n,
    inout  wire  [31:0] DDT
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] load_val;
    logic        we_q;
    logic [1:0]  size_q;
    logic [2:0]  funct3_q;
    logic        rsp_valid_q;
    logic        misalign_q;
    logic        accept;
    logic        ack;
    logic        trap;
    logic        busy;
    logic        drive_ddt;

`ifdef DMEM_BUS_IF_MISALIGN_TRAP_EN
    assign trap = is_misaligned(size_of(req_funct3), req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Next-state and decoded control; the rsp_valid cycle blocks a new accept.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        accept    = 1'b0;
        ack       = 1'b0;
        drive_ddt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = req_valid && !rsp_valid_q;
                if (accept && !trap) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy      = 1'b1;
                ack       = !ACKD_n;
                drive_ddt = we_q;
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch; trapped requests never touch the bus-facing registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            we_q     <= 1'b0;
            size_q   <= SZ_WORD;
            funct3_q <= 3'b000;
        end else if (accept && !trap) begin
            addr_q   <= req_addr;
            wdata_q  <= store_lane(size_of(req_funct3), req_wdata);
            we_q     <= req_we;
            size_q   <= size_of(req_funct3);
            funct3_q <= req_funct3;
        end
    end

    // Completion pulse, trap flag and load-result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            rsp_valid_q <= ack || (accept && trap);
            misalign_q  <= accept && trap;
            if (ack && !we_q) begin
                rdata_q <= load_val;
            end
        end
    end

    dmem_load_ext u_load_ext (
        .funct3 (funct3_q),
        .raw    (DDT),
        .ext    (load_val)
    );

    // Reset gates stall so the pipeline is never frozen while held in reset.
    assign stall     = rst && (accept || busy);
    assign rsp_valid = rsp_valid_q;
    assign misalign  = misalign_q;
    assign rsp_rdata = rdata_q;
    assign MREQ      = busy;
    assign WRITE     = we_q;
    assign SIZE      = size_q;
    assign DAD       = addr_q;
    assign DDT       = drive_ddt ? wdata_q : {32{1'bz}};

endmodule
